// File: rtl/gpc_trace_mon_pkg.sv
// Shared types and constants for the GPC trace monitor slice.
package gpc_trace_pkg;

   typedef enum logic [1:0] {
      ARMED     = 2'd0,
      TRIGGERED = 2'd1,
      FROZEN    = 2'd2
   } trig_state_t;

   // Bit positions inside the entry kind field
   localparam int KIND_REG_WR  = 0;
   localparam int KIND_MEM_RD  = 1;
   localparam int KIND_MEM_WR  = 2;
   localparam int KIND_SHRD_WR = 3;

   // Error vector layout: external pulses first, then the two internal checks
   localparam int ERR_EXT_W      = 4;
   localparam int ERR_ILL_REG    = ERR_EXT_W;
   localparam int ERR_BAD_THREAD = ERR_EXT_W + 1;

   localparam int ENTRY_TS_W  = 16;
   localparam int ENTRY_TID_W = 2;

   localparam logic [31:0] SHRD_LO_DEF = 32'h00400F00;
   localparam logic [31:0] SHRD_HI_DEF = 32'h00400FFF;

   typedef struct packed {
      logic [ENTRY_TS_W-1:0]  ts;
      logic [ENTRY_TID_W-1:0] tid;
      logic [3:0]             kind;
      logic [4:0]             regPtr;
      logic [31:0]            addr;
      logic [31:0]            memData;
      logic [31:0]            regData;
   } trc_entry_t;

   localparam int ENTRY_W = $bits(trc_entry_t);

endpackage

// File: rtl/gpc_trace_mon_if.sv
// Core-side Q104H tap plus the valid/ready trace drain port.
interface gpc_trace_mon_if
   import gpc_trace_pkg::*;
#(
   parameter int NUM_THREADS = 4,
   parameter int ERR_W       = 4
);

   logic [NUM_THREADS-1:0] ThreadQ104H;
   logic                   CtrlRegWrQ104H;
   logic [4:0]             RegWrPtrQ104H;
   logic [31:0]            RegWrDataQ104H;
   logic                   CtrlMemRdQ104H;
   logic                   CtrlMemWrQ104H;
   logic [31:0]            MemAdrsQ104H;
   logic [31:0]            MemDataQ104H;
   logic [ERR_W-1:0]       ErrInQ104H;
   logic                   TrcValid;
   logic                   TrcReady;
   trc_entry_t             TrcEntry;

   // The monitor observes the core and sources trace entries
   modport master (
      input  ThreadQ104H, CtrlRegWrQ104H, RegWrPtrQ104H, RegWrDataQ104H,
      input  CtrlMemRdQ104H, CtrlMemWrQ104H, MemAdrsQ104H, MemDataQ104H,
      input  ErrInQ104H, TrcReady,
      output TrcValid, TrcEntry
   );

   // The core drives the tap and a consumer drains entries
   modport slave (
      output ThreadQ104H, CtrlRegWrQ104H, RegWrPtrQ104H, RegWrDataQ104H,
      output CtrlMemRdQ104H, CtrlMemWrQ104H, MemAdrsQ104H, MemDataQ104H,
      output ErrInQ104H, TrcReady,
      input  TrcValid, TrcEntry
   );

endinterface

// File: rtl/gpc_trace_mon_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head reads as zero while empty.
module gpc_trace_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
)(
   input  logic             clk,
   input  logic             rstN,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wrData,
   output logic [WIDTH-1:0] rdData,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wrPtr, rdPtr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             doPush, doPop;

   assign empty  = (wrPtr == rdPtr);
   assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign doPop  = pop && !empty;
   assign doPush = push && (!full || doPop);
   assign rdData = empty ? '0 : mem[rdPtr[AW-1:0]];

   // Pointer bookkeeping; flush behaves like reset for occupancy
   always_ff @(posedge clk) begin
      if (!rstN || flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
      end
   end

   // Storage write; contents need no reset because empty masks the head
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr[AW-1:0]] <= wrData;
   end

endmodule

// File: rtl/gpc_trace_mon.sv
// Per-cycle trace and assertion monitor for the N-thread GPC core.
module gpc_trace_mon
   import gpc_trace_pkg::*;
#(
   parameter int               NUM_THREADS = 4,
   parameter int               TID_W       = $clog2(NUM_THREADS),
   parameter int               FIFO_DEPTH  = 16,
   parameter int               TS_W        = 16,
   parameter int               NUM_REGS    = 16,
   parameter int               ERR_W       = 4,
   parameter logic [ERR_W+1:0] FATAL_MASK  = 'b0110,
   parameter int               POST_TRIG   = 4,
   parameter logic [31:0]      SHRD_LO     = SHRD_LO_DEF,
   parameter logic [31:0]      SHRD_HI     = SHRD_HI_DEF
)(
   input  logic                   QClk,
   input  logic                   RstQnnnL,
   gpc_trace_mon_if.master        trc,
   input  logic [NUM_THREADS-1:0] ThreadEnMask,
   input  logic                   ClearQ,
   output logic [15:0]            DropCnt,
   output logic [ERR_W+1:0]       ErrSticky,
   output logic [TS_W-1:0]        FirstErrTs,
   output logic [TID_W-1:0]       FirstErrTid,
   output logic [1:0]             TrigState,
   output logic                   HaltReq
);

   trig_state_t      state;
   logic [15:0]      postCnt;
   logic [TS_W-1:0]  ts;
   logic [TID_W-1:0] tidRaw, tidNow;
   logic             oneHot, illReg, hasEvent;
   logic [3:0]       kindNow;
   logic [ERR_W+1:0] errNow;
   logic             pushReq, pushAcc, dropNow, popNow;
   logic             fifoFull, fifoEmpty;
   trc_entry_t       newEntry;

   assign TrigState   = state;
   assign trc.TrcValid = !fifoEmpty;
   assign popNow      = trc.TrcValid && trc.TrcReady;

   // Decode thread, classify the event, collect this cycle's errors and decide push/drop
   always_comb begin
      tidRaw = '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
         if (trc.ThreadQ104H[i]) tidRaw = TID_W'(i);
      end
      oneHot = ($countones(trc.ThreadQ104H) == 1);
      tidNow = oneHot ? tidRaw : '0;

      kindNow = '0;
      kindNow[KIND_REG_WR]  = trc.CtrlRegWrQ104H && (trc.RegWrPtrQ104H != 5'd0);
      kindNow[KIND_MEM_RD]  = trc.CtrlMemRdQ104H;
      kindNow[KIND_MEM_WR]  = trc.CtrlMemWrQ104H;
      kindNow[KIND_SHRD_WR] = trc.CtrlMemWrQ104H && (trc.MemAdrsQ104H >= SHRD_LO)
                              && (trc.MemAdrsQ104H < SHRD_HI);
      hasEvent = |kindNow;

      illReg = trc.CtrlRegWrQ104H && (32'(trc.RegWrPtrQ104H) >= NUM_REGS);
      errNow = {!oneHot && hasEvent, illReg, trc.ErrInQ104H};

      pushReq = hasEvent && ThreadEnMask[tidNow] && !ClearQ && (state != FROZEN);
      pushAcc = pushReq && (!fifoFull || popNow);
      dropNow = pushReq && fifoFull && !popNow;

      newEntry = '{ts: ts, tid: tidNow, kind: kindNow, regPtr: trc.RegWrPtrQ104H,
                   addr: trc.MemAdrsQ104H, memData: trc.MemDataQ104H,
                   regData: trc.RegWrDataQ104H};
   end

   gpc_trace_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) traceFifo (
      .clk    (QClk),
      .rstN   (RstQnnnL),
      .flush  (ClearQ),
      .push   (pushAcc),
      .pop    (popNow),
      .wrData (newEntry),
      .rdData (trc.TrcEntry),
      .full   (fifoFull),
      .empty  (fifoEmpty)
   );

   // Free-running timestamp; only reset restarts it, ClearQ does not
   always_ff @(posedge QClk) begin
      if (!RstQnnnL) ts <= '0;
      else           ts <= ts + TS_W'(1);
   end

   // Drop counter, sticky errors and first-error capture
   always_ff @(posedge QClk) begin
      if (!RstQnnnL || ClearQ) begin
         DropCnt     <= '0;
         ErrSticky   <= '0;
         FirstErrTs  <= '0;
         FirstErrTid <= '0;
      end else begin
         if (dropNow && (DropCnt != 16'hFFFF)) DropCnt <= DropCnt + 16'd1;
         ErrSticky <= ErrSticky | errNow;
         if ((ErrSticky == '0) && (errNow != '0)) begin
            FirstErrTs  <= ts;
            FirstErrTid <= tidNow;
         end
      end
   end

   // Trigger FSM: count accepted pushes after a fatal error, then freeze capture
   always_ff @(posedge QClk) begin
      if (!RstQnnnL || ClearQ) begin
         state   <= ARMED;
         postCnt <= '0;
         HaltReq <= 1'b0;
      end else begin
         case (state)
            ARMED: begin
               if (|(errNow & FATAL_MASK)) begin
                  state   <= TRIGGERED;
                  postCnt <= 16'(POST_TRIG);
               end
            end
            TRIGGERED: begin
               if (postCnt == 16'd0) begin
                  state   <= FROZEN;
                  HaltReq <= 1'b1;
               end else if (pushAcc) begin
                  postCnt <= postCnt - 16'd1;
                  if (postCnt == 16'd1) begin
                     state   <= FROZEN;
                     HaltReq <= 1'b1;
                  end
               end
            end
            FROZEN: HaltReq <= 1'b1;
            default: begin
               state   <= ARMED;
               HaltReq <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gpc_trace_mon.sv
// Directed scoreboard bench for gpc_trace_mon.
module tb_gpc_trace_mon;
   import gpc_trace_pkg::*;

   logic        QClk = 1'b0;
   logic        RstQnnnL;
   logic [3:0]  ThreadEnMask;
   logic        ClearQ;
   logic [15:0] DropCnt;
   logic [5:0]  ErrSticky;
   logic [15:0] FirstErrTs;
   logic [1:0]  FirstErrTid;
   logic [1:0]  TrigState;
   logic        HaltReq;

   int          checks = 0;
   int          errors = 0;
   trc_entry_t  expQ[$];
   logic [15:0] tbTs = 16'd0;

   gpc_trace_mon_if #(.NUM_THREADS(4), .ERR_W(4)) trc ();

   gpc_trace_mon dut (
      .QClk         (QClk),
      .RstQnnnL     (RstQnnnL),
      .trc          (trc),
      .ThreadEnMask (ThreadEnMask),
      .ClearQ       (ClearQ),
      .DropCnt      (DropCnt),
      .ErrSticky    (ErrSticky),
      .FirstErrTs   (FirstErrTs),
      .FirstErrTid  (FirstErrTid),
      .TrigState    (TrigState),
      .HaltReq      (HaltReq)
   );

   // Clock generation
   always #5 QClk = ~QClk;

   // Reference timestamp: zero in the first cycle after reset, then counts every edge
   always @(posedge QClk) tbTs <= (RstQnnnL === 1'b0) ? 16'd0 : tbTs + 16'd1;

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every pop the DUT is about to take must match the oldest expected entry
   always @(negedge QClk) begin
      if (RstQnnnL === 1'b1 && ClearQ === 1'b0 && trc.TrcValid === 1'b1 && trc.TrcReady === 1'b1) begin
         checkOutput("scoreboardHasEntry", 128'(expQ.size() != 0), 128'(1));
         if (expQ.size() != 0) checkOutput("entry", 128'(trc.TrcEntry), 128'(expQ.pop_front()));
      end
   end

   task automatic setIdle();
      trc.ThreadQ104H    = 4'b0001;
      trc.CtrlRegWrQ104H = 1'b0;
      trc.RegWrPtrQ104H  = 5'd0;
      trc.RegWrDataQ104H = 32'd0;
      trc.CtrlMemRdQ104H = 1'b0;
      trc.CtrlMemWrQ104H = 1'b0;
      trc.MemAdrsQ104H   = 32'd0;
      trc.MemDataQ104H   = 32'd0;
      trc.ErrInQ104H     = 4'd0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge QClk);
         #1;
      end
   endtask

   // Drive one cycle of tap inputs and record the entry it should produce
   task automatic applyStimulus(input logic [3:0] thr, input logic regWr, input logic [4:0] ptr,
                                input logic [31:0] rData, input logic rd, input logic wr,
                                input logic [31:0] adr, input logic [31:0] mData,
                                input logic [3:0] err, input logic capture,
                                input logic [1:0] expTid, input logic [3:0] expKind);
      trc.ThreadQ104H    = thr;
      trc.CtrlRegWrQ104H = regWr;
      trc.RegWrPtrQ104H  = ptr;
      trc.RegWrDataQ104H = rData;
      trc.CtrlMemRdQ104H = rd;
      trc.CtrlMemWrQ104H = wr;
      trc.MemAdrsQ104H   = adr;
      trc.MemDataQ104H   = mData;
      trc.ErrInQ104H     = err;
      if (capture) expQ.push_back('{ts: tbTs, tid: expTid, kind: expKind, regPtr: ptr,
                                    addr: adr, memData: mData, regData: rData});
      @(posedge QClk);
      #1;
      setIdle();
   endtask

   task automatic waitDrain(input string tag, input int maxCycles);
      int n = 0;
      while (expQ.size() != 0 && n < maxCycles) begin
         idle(1);
         n++;
      end
      checkOutput(tag, 128'(expQ.size()), 128'(0));
   endtask

   task automatic pulseClear();
      ClearQ = 1'b1;
      idle(1);
      ClearQ = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int guard;
      RstQnnnL     = 1'b0;
      ClearQ       = 1'b0;
      ThreadEnMask = 4'hF;
      trc.TrcReady = 1'b0;
      setIdle();
      idle(2);

      // Reset state
      checkOutput("rstValid", 128'(trc.TrcValid), 128'(0));
      checkOutput("rstEntry", 128'(trc.TrcEntry), 128'(0));
      checkOutput("rstDropCnt", 128'(DropCnt), 128'(0));
      checkOutput("rstErrSticky", 128'(ErrSticky), 128'(0));
      checkOutput("rstFirstErrTs", 128'(FirstErrTs), 128'(0));
      checkOutput("rstFirstErrTid", 128'(FirstErrTid), 128'(0));
      checkOutput("rstTrigState", 128'(TrigState), 128'(0));
      checkOutput("rstHaltReq", 128'(HaltReq), 128'(0));
      RstQnnnL     = 1'b1;
      trc.TrcReady = 1'b1;

      // Register write, one-cycle latency, x0 ignored
      checkOutput("validBeforePush", 128'(trc.TrcValid), 128'(0));
      applyStimulus(4'b0100, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 4'd0, 1, 2'd2, 4'b0001);
      checkOutput("validLatency", 128'(trc.TrcValid), 128'(1));
      applyStimulus(4'b0100, 1, 5'd0, 32'h11111111, 0, 0, 0, 0, 4'd0, 0, 2'd0, 4'b0000);
      idle(2);
      checkOutput("x0NoEntry", 128'(trc.TrcValid), 128'(0));

      // Memory kinds and shared-space bounds
      applyStimulus(4'b0001, 0, 5'd0, 0, 0, 1, 32'h00400F10, 32'd7, 4'd0, 1, 2'd0, 4'b1100);
      applyStimulus(4'b0001, 0, 5'd0, 0, 0, 1, 32'h00400FFF, 32'd8, 4'd0, 1, 2'd0, 4'b0100);
      applyStimulus(4'b0001, 0, 5'd0, 0, 0, 1, 32'h00400F00, 32'd9, 4'd0, 1, 2'd0, 4'b1100);
      applyStimulus(4'b1000, 0, 5'd0, 0, 1, 0, 32'h00001000, 32'hCAFEF00D, 4'd0, 1, 2'd3, 4'b0010);
      ThreadEnMask = 4'b0111;
      applyStimulus(4'b1000, 1, 5'd3, 32'h33, 0, 0, 0, 0, 4'd0, 0, 2'd3, 4'b0001);
      ThreadEnMask = 4'hF;
      waitDrain("drainMem", 10);
      checkOutput("maskedNoEntry", 128'(trc.TrcValid), 128'(0));

      // Overflow: 20 events into 16 slots, then push+pop while full
      trc.TrcReady = 1'b0;
      for (int i = 0; i < 20; i++)
         applyStimulus(4'b0001, 1, 5'd1, 32'(i), 0, 0, 0, 0, 4'd0, (i < 16), 2'd0, 4'b0001);
      checkOutput("fullValid", 128'(trc.TrcValid), 128'(1));
      checkOutput("dropCnt4", 128'(DropCnt), 128'(4));
      trc.TrcReady = 1'b1;
      applyStimulus(4'b0010, 1, 5'd2, 32'hF00D, 0, 0, 0, 0, 4'd0, 1, 2'd1, 4'b0001);
      trc.TrcReady = 1'b0;
      checkOutput("dropCntPushPop", 128'(DropCnt), 128'(4));
      trc.TrcReady = 1'b1;
      waitDrain("drainFull", 40);
      pulseClear();
      checkOutput("clearDropCnt", 128'(DropCnt), 128'(0));

      // Fatal error at ts=100, four post-trigger entries, then frozen
      guard = 0;
      while (tbTs != 16'd100 && guard < 300) begin
         idle(1);
         guard++;
      end
      applyStimulus(4'b0010, 1, 5'd3, 32'hA, 0, 0, 0, 0, 4'b0010, 1, 2'd1, 4'b0001);
      checkOutput("trigState1", 128'(TrigState), 128'(1));
      checkOutput("trigErrSticky", 128'(ErrSticky), 128'(6'b000010));
      checkOutput("firstErrTs100", 128'(FirstErrTs), 128'(100));
      checkOutput("firstErrTid1", 128'(FirstErrTid), 128'(1));
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'b0001, 1, 5'd4, 32'(i + 100), 0, 0, 0, 0, 4'd0, 1, 2'd0, 4'b0001);
         checkOutput("postTrigState", 128'(TrigState), (i == 3) ? 128'(2) : 128'(1));
      end
      checkOutput("haltReqFrozen", 128'(HaltReq), 128'(1));
      applyStimulus(4'b0001, 1, 5'd6, 32'h66, 0, 0, 0, 0, 4'd0, 0, 2'd0, 4'b0001);
      applyStimulus(4'b0100, 0, 5'd0, 0, 0, 1, 32'h00400F20, 32'h5, 4'd0, 0, 2'd2, 4'b1100);
      checkOutput("frozenNoDrop", 128'(DropCnt), 128'(0));
      applyStimulus(4'b0001, 0, 5'd0, 0, 0, 0, 0, 0, 4'b0001, 0, 2'd0, 4'b0000);
      checkOutput("laterErrSticky", 128'(ErrSticky), 128'(6'b000011));
      checkOutput("firstErrTsKept", 128'(FirstErrTs), 128'(100));
      waitDrain("drainFrozen", 20);
      idle(1);
      checkOutput("frozenDrained", 128'(trc.TrcValid), 128'(0));

      // Illegal register and bad thread vector, then ClearQ beating a new error
      pulseClear();
      checkOutput("clearTrigState", 128'(TrigState), 128'(0));
      checkOutput("clearHaltReq", 128'(HaltReq), 128'(0));
      applyStimulus(4'b0011, 1, 5'd20, 32'h5555, 0, 0, 0, 0, 4'd0, 1, 2'd0, 4'b0001);
      checkOutput("illRegBadThr", 128'(ErrSticky), 128'(6'b110000));
      checkOutput("nonFatalArmed", 128'(TrigState), 128'(0));
      checkOutput("badThrFirstTid", 128'(FirstErrTid), 128'(0));
      applyStimulus(4'b0100, 0, 5'd0, 0, 1, 1, 32'h2000, 32'h77, 4'b0001, 1, 2'd2, 4'b0110);
      checkOutput("rdWrErrSticky", 128'(ErrSticky), 128'(6'b110001));
      waitDrain("drainErr", 10);
      pulseClear();
      applyStimulus(4'b0000, 0, 5'd0, 0, 0, 0, 0, 0, 4'd0, 0, 2'd0, 4'b0000);
      checkOutput("noEventNoErr", 128'(ErrSticky), 128'(0));
      ClearQ = 1'b1;
      applyStimulus(4'b0001, 1, 5'd6, 32'h99, 0, 0, 0, 0, 4'b0010, 0, 2'd0, 4'b0001);
      ClearQ = 1'b0;
      checkOutput("clearBeatsErr", 128'(ErrSticky), 128'(0));
      checkOutput("clearBeatsTrig", 128'(TrigState), 128'(0));
      checkOutput("clearFirstTs", 128'(FirstErrTs), 128'(0));
      idle(1);
      checkOutput("clearBeatsPush", 128'(trc.TrcValid), 128'(0));

      // Reset mid-drain with 8 entries buffered
      trc.TrcReady = 1'b0;
      for (int i = 0; i < 8; i++)
         applyStimulus(4'b0001, 1, (i == 0) ? 5'd30 : 5'd2, 32'(i + 200), 0, 0, 0, 0, 4'd0, 1, 2'd0, 4'b0001);
      trc.TrcReady = 1'b1;
      idle(2);
      trc.TrcReady = 1'b0;
      RstQnnnL = 1'b0;
      expQ.delete();
      idle(1);
      checkOutput("midRstValid", 128'(trc.TrcValid), 128'(0));
      checkOutput("midRstEntry", 128'(trc.TrcEntry), 128'(0));
      checkOutput("midRstDropCnt", 128'(DropCnt), 128'(0));
      checkOutput("midRstHaltReq", 128'(HaltReq), 128'(0));
      checkOutput("midRstErrSticky", 128'(ErrSticky), 128'(0));
      RstQnnnL = 1'b1;
      applyStimulus(4'b0001, 1, 5'd7, 32'hBEEF, 0, 0, 0, 0, 4'd0, 1, 2'd0, 4'b0001);
      checkOutput("tsRestart", 128'(trc.TrcEntry.ts), 128'(0));
      trc.TrcReady = 1'b1;
      waitDrain("drainFinal", 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
